domain_bus_arb: RTL and testbench

Parametrised shared-bus arbiter that lets `N_CHAN` CPU domains drive one external memory bus through registered outputs. It generalises the single-domain registered bus latch to multiple requesters with round-robin fairness, a valid/ready bus handshake, and read-data return. It sits between the domain instances and the top-level bus pins.

---
 rtl/domain_pkg.sv | 13 +
 rtl/domain_bus_arb_if.sv | 36 +++
 rtl/domain_bus_arb_rr_pick.sv | 32 +++
 rtl/domain_bus_arb.sv | 154 +++++++++++++++
 tb/tb_domain_bus_arb.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/domain_pkg.sv
// Shared types and default bus widths for the domain bus arbiter slice.
package domain_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } arb_state_t;

    localparam int BUS_ADDR_W = 17;
    localparam int BUS_DATA_W = 8;

endpackage

// File: rtl/domain_bus_arb_if.sv
// Requester and external bus signals of the domain bus arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface domain_bus_arb_if
    import domain_pkg::*;
#(
    parameter int N_CHAN = 4,
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) ();

    logic [N_CHAN-1:0]        req;
    logic [N_CHAN-1:0]        req_we;
    logic [N_CHAN*ADDR_W-1:0] req_addr;
    logic [N_CHAN*DATA_W-1:0] req_wdata;
    logic [N_CHAN-1:0]        gnt;
    logic [N_CHAN-1:0]        done;
    logic [N_CHAN-1:0]        err;
    logic [DATA_W-1:0]        rdata;
    logic                     bus_valid;
    logic                     bus_we;
    logic [ADDR_W-1:0]        bus_addr;
    logic [DATA_W-1:0]        bus_wdata;
    logic [DATA_W-1:0]        bus_in;
    logic                     bus_ready;

    modport master (
        input  req, req_we, req_addr, req_wdata, bus_in, bus_ready,
        output gnt, done, err, rdata, bus_valid, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        output req, req_we, req_addr, req_wdata, bus_in, bus_ready,
        input  gnt, done, err, rdata, bus_valid, bus_we, bus_addr, bus_wdata
    );

endinterface

// File: rtl/domain_bus_arb_rr_pick.sv
// Combinational round-robin selector: first requesting channel after 'last',
// wrapping modulo N_CHAN.
module rr_pick #(
    parameter int  N_CHAN = 4,
    localparam int IDX_W  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic [N_CHAN-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic [N_CHAN-1:0] pick,
    output logic [IDX_W-1:0]  pick_idx,
    output logic              any
);

    logic [IDX_W-1:0] cand;

    // Walk the channels in priority order starting just after the last winner
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        cand     = '0;
        for (int k = 1; k <= N_CHAN; k++) begin
            cand = IDX_W'((int'(last) + k) % N_CHAN);
            if (!any && req[cand]) begin
                any        = 1'b1;
                pick_idx   = cand;
                pick[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/domain_bus_arb.sv
// Round-robin arbiter letting N_CHAN CPU domains share one registered
// external memory bus with a valid/ready handshake and read-data return.
// Optional feature macro: DOMAIN_ARB_TIMEOUT_EN adds a bus-wait timeout that
// completes a stuck transfer with err/done pulses and rdata = 0.
module domain_bus_arb
    import domain_pkg::*;
#(
    parameter int N_CHAN  = 4,
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 15
) (
    input logic               clk,
    input logic               reset,
    domain_bus_arb_if.master  bus
);

    localparam int IDX_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

    if (N_CHAN < 2 || TIMEOUT < 1) begin : g_param_check
        $error("domain_bus_arb: N_CHAN must be >= 2 and TIMEOUT >= 1");
    end

    arb_state_t        state;
    logic [IDX_W-1:0]  last;
    logic [IDX_W-1:0]  win_idx;
    logic [N_CHAN-1:0] gnt_q;
    logic [N_CHAN-1:0] done_q;
    logic [DATA_W-1:0] rdata_q;
    logic              bus_valid_q;
    logic              bus_we_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;

    logic [N_CHAN-1:0] pick;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              timeout_hit;

`ifdef DOMAIN_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  wait_cnt;
    logic [N_CHAN-1:0] err_q;

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1)) && !bus.bus_ready;
    assign bus.err     = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = '0;
`endif

    rr_pick #(.N_CHAN(N_CHAN)) u_pick (
        .req      (bus.req),
        .last     (last),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    // Select the candidate winner's request fields for registering onto the bus
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (pick[i]) begin
                win_we    = bus.req_we[i];
                win_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                win_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Arbitration FSM with all bus and completion outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last        <= IDX_W'(N_CHAN - 1);
            win_idx     <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
`ifdef DOMAIN_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
            err_q       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_q <= '0;
                    if (pick_any) begin
                        state       <= XFER;
                        gnt_q       <= pick;
                        win_idx     <= pick_idx;
                        bus_valid_q <= 1'b1;
                        bus_we_q    <= win_we;
                        bus_addr_q  <= win_addr;
                        bus_wdata_q <= win_wdata;
`ifdef DOMAIN_ARB_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end
                end
                XFER: begin
                    if (bus.bus_ready) begin
                        state       <= DONE;
                        rdata_q     <= bus.bus_in;
                        bus_valid_q <= 1'b0;
                        last        <= win_idx;
                        done_q      <= gnt_q;
                    end else if (timeout_hit) begin
                        state       <= DONE;
                        rdata_q     <= '0;
                        bus_valid_q <= 1'b0;
                        last        <= win_idx;
                        done_q      <= gnt_q;
`ifdef DOMAIN_ARB_TIMEOUT_EN
                        err_q       <= gnt_q;
`endif
                    end else begin
`ifdef DOMAIN_ARB_TIMEOUT_EN
                        wait_cnt    <= wait_cnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= '0;
                    gnt_q  <= '0;
`ifdef DOMAIN_ARB_TIMEOUT_EN
                    err_q  <= '0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_domain_bus_arb.sv
// Self-checking bench for domain_bus_arb: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin model.
// Timeout scenarios are compiled in when DOMAIN_ARB_TIMEOUT_EN is defined.
module tb_domain_bus_arb;

    localparam int N  = 4;
    localparam int AW = 17;
    localparam int DW = 8;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    domain_bus_arb_if #(.N_CHAN(N), .ADDR_W(AW), .DATA_W(DW)) bus_if ();

    domain_bus_arb #(.N_CHAN(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    logic [N-1:0]  req_m;
    logic          we_m    [N];
    logic [AW-1:0] addr_m  [N];
    logic [DW-1:0] wdata_m [N];
    int            last_m;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drivePins();
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d;
        logic [N-1:0]    w;
        a = '0;
        d = '0;
        w = '0;
        for (int i = 0; i < N; i++) begin
            a = a | ((N*AW)'(addr_m[i]) << (i*AW));
            d = d | ((N*DW)'(wdata_m[i]) << (i*DW));
            w = w | (N'(we_m[i]) << i);
        end
        bus_if.req       = req_m;
        bus_if.req_we    = w;
        bus_if.req_addr  = a;
        bus_if.req_wdata = d;
    endtask

    task automatic setChannel(input int i, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        we_m[i]    = we;
        addr_m[i]  = addr;
        wdata_m[i] = wd;
        req_m      = req_m | (N'(1) << i);
        drivePins();
    endtask

    task automatic dropChannel(input int i);
        req_m = req_m & ~(N'(1) << i);
        drivePins();
    endtask

    task automatic raiseRandom();
        for (int i = 0; i < N; i++) begin
            if (((req_m >> i) & N'(1)) == '0 && ($urandom % 2) == 0)
                setChannel(i, 1'($urandom), AW'($urandom), DW'($urandom));
        end
    endtask

    // Round-robin rule: first requester strictly after the previous winner
    function automatic int pickModel(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (((r >> ((last + k) % N)) & N'(1)) != '0)
                return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"},   32'(bus_if.gnt),       32'h0);
        checkOutput({tag, "_done"},  32'(bus_if.done),      32'h0);
        checkOutput({tag, "_err"},   32'(bus_if.err),       32'h0);
        checkOutput({tag, "_rdata"}, 32'(bus_if.rdata),     32'h0);
        checkOutput({tag, "_valid"}, 32'(bus_if.bus_valid), 32'h0);
        checkOutput({tag, "_we"},    32'(bus_if.bus_we),    32'h0);
        checkOutput({tag, "_addr"},  32'(bus_if.bus_addr),  32'h0);
        checkOutput({tag, "_wdata"}, 32'(bus_if.bus_wdata), 32'h0);
    endtask

    // One full transaction from an IDLE cycle: grant, 'delay' wait cycles, done, back to IDLE
    task automatic applyStimulus(input int delay, input logic [DW-1:0] rd, input logic keep,
                                 input int exp_w, input logic churn, input string tag);
        logic [N-1:0] g1;
        g1 = N'(1) << exp_w;
        @(posedge clk); #1;
        checkOutput({tag, "_gnt"},   32'(bus_if.gnt),       32'(g1));
        checkOutput({tag, "_valid"}, 32'(bus_if.bus_valid), 32'h1);
        checkOutput({tag, "_we"},    32'(bus_if.bus_we),    32'(we_m[exp_w]));
        checkOutput({tag, "_addr"},  32'(bus_if.bus_addr),  32'(addr_m[exp_w]));
        checkOutput({tag, "_wdata"}, 32'(bus_if.bus_wdata), 32'(wdata_m[exp_w]));
        checkOutput({tag, "_nodone"}, 32'(bus_if.done),     32'h0);
        for (int c = 0; c <= delay; c++) begin
            bus_if.bus_ready = (c == delay);
            bus_if.bus_in    = (c == delay) ? rd : DW'($urandom);
            if (churn) raiseRandom();
            @(posedge clk); #1;
            if (c < delay) begin
                checkOutput({tag, "_hold_valid"}, 32'(bus_if.bus_valid), 32'h1);
                checkOutput({tag, "_hold_gnt"},   32'(bus_if.gnt),       32'(g1));
                checkOutput({tag, "_hold_addr"},  32'(bus_if.bus_addr),  32'(addr_m[exp_w]));
                checkOutput({tag, "_hold_wdata"}, 32'(bus_if.bus_wdata), 32'(wdata_m[exp_w]));
                checkOutput({tag, "_hold_done"},  32'(bus_if.done),      32'h0);
            end
        end
        bus_if.bus_ready = 1'b0;
        bus_if.bus_in    = DW'($urandom);
        checkOutput({tag, "_done"},      32'(bus_if.done),      32'(g1));
        checkOutput({tag, "_err"},       32'(bus_if.err),       32'h0);
        checkOutput({tag, "_rdata"},     32'(bus_if.rdata),     32'(rd));
        checkOutput({tag, "_done_gnt"},  32'(bus_if.gnt),       32'(g1));
        checkOutput({tag, "_done_valid"}, 32'(bus_if.bus_valid), 32'h0);
        last_m = exp_w;
        if (!keep) dropChannel(exp_w);
        @(posedge clk); #1;
        checkOutput({tag, "_idle_done"}, 32'(bus_if.done), 32'h0);
        checkOutput({tag, "_idle_gnt"},  32'(bus_if.gnt),  32'h0);
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [DW-1:0] rd;
        int w;
        reset            = 1'b1;
        req_m            = '0;
        bus_if.bus_ready = 1'b0;
        bus_if.bus_in    = '0;
        for (int i = 0; i < N; i++) begin
            we_m[i]    = 1'b0;
            addr_m[i]  = '0;
            wdata_m[i] = '0;
        end
        drivePins();
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        reset  = 1'b0;
        last_m = N - 1;

        // Single ch0 read at the minimum latency
        $display("[TB] single read on ch0");
        setChannel(0, 1'b0, 17'h00010, 8'h00);
        applyStimulus(0, 8'hA5, 1'b0, 0, 1'b0, "t1");

        // Reset in the middle of a transfer abandons it
        $display("[TB] reset during XFER");
        setChannel(2, 1'b1, AW'($urandom), DW'($urandom));
        @(posedge clk); #1;
        checkOutput("rstmid_gnt",   32'(bus_if.gnt),       32'h4);
        checkOutput("rstmid_valid", 32'(bus_if.bus_valid), 32'h1);
        reset = 1'b1;
        dropChannel(2);
        setChannel(0, 1'b0, AW'($urandom), DW'($urandom));
        setChannel(1, 1'b1, AW'($urandom), DW'($urandom));
        @(posedge clk); #1;
        checkAllZero("rstmid");
        reset  = 1'b0;
        last_m = N - 1;
        applyStimulus(0, DW'($urandom), 1'b0, 0, 1'b0, "post_rst");
        dropChannel(1);

        // Ch2 write with a 5-cycle ready delay
        $display("[TB] delayed write on ch2");
        setChannel(2, 1'b1, AW'($urandom), 8'h3C);
        applyStimulus(5, DW'($urandom), 1'b0, 2, 1'b0, "t3");

        // All channels requesting continuously after a fresh reset
        $display("[TB] round-robin order");
        reset = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        last_m = N - 1;
        for (int i = 0; i < N; i++) setChannel(i, 1'($urandom), AW'($urandom), DW'($urandom));
        for (int k = 0; k < 5; k++) applyStimulus(0, DW'($urandom), 1'b1, k % N, 1'b0, "order");
        req_m = '0;
        drivePins();

        // Randomized traffic against the round-robin model
        $display("[TB] random traffic");
        for (int t = 0; t < 40; t++) begin
            raiseRandom();
            if (req_m == '0) setChannel(int'($urandom % N), 1'($urandom), AW'($urandom), DW'($urandom));
            w = pickModel(req_m, last_m);
            applyStimulus(int'($urandom_range(0, 3)), DW'($urandom), 1'(($urandom % 4) == 0), w, 1'b1, "rand");
        end
        req_m = '0;
        drivePins();

`ifdef DOMAIN_ARB_TIMEOUT_EN
        $display("[TB] bus timeout");
        setChannel(3, 1'b0, AW'($urandom), DW'($urandom));
        applyStimulus(0, 8'h5A, 1'b0, 3, 1'b0, "pre_to");
        setChannel(1, 1'b0, AW'($urandom), DW'($urandom));
        w = pickModel(req_m, last_m);
        @(posedge clk); #1;
        checkOutput("to_gnt", 32'(bus_if.gnt), 32'(N'(1) << w));
        for (int c = 1; c < TO; c++) begin
            bus_if.bus_in = DW'($urandom);
            @(posedge clk); #1;
            checkOutput("to_wait_valid", 32'(bus_if.bus_valid), 32'h1);
            checkOutput("to_wait_done",  32'(bus_if.done),      32'h0);
        end
        @(posedge clk); #1;
        checkOutput("to_done",  32'(bus_if.done),      32'(N'(1) << w));
        checkOutput("to_err",   32'(bus_if.err),       32'(N'(1) << w));
        checkOutput("to_rdata", 32'(bus_if.rdata),     32'h0);
        checkOutput("to_valid", 32'(bus_if.bus_valid), 32'h0);
        last_m = w;
        dropChannel(w);
        @(posedge clk); #1;
        checkOutput("to_idle_err", 32'(bus_if.err), 32'h0);

        $display("[TB] ready on the last allowed cycle");
        setChannel(2, 1'b1, AW'($urandom), DW'($urandom));
        w  = pickModel(req_m, last_m);
        rd = 8'hC3;
        applyStimulus(TO - 1, rd, 1'b0, w, 1'b0, "to_edge");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
